lab4_branch_resolve_queue: RTL

Branch resolution queue that closes the loop on the bimodal predictor. Each fetch-stage prediction (PC plus predicted direction) is recorded in program order. When execute resolves the oldest branch, the block compares the actual outcome with the prediction. It then drives the predictor's `update_en`/`update_val` training port and raises a mispredict pulse that squashes all younger in-flight branch records.

---
 rtl/lab4_branch_resolve_queue.sv | 100 ++++++++++
 1 files changed

// File: rtl/lab4_branch_resolve_queue.sv
// Branch resolution queue: records fetch predictions in program order, trains the
// predictor on resolve and squashes younger records on a mispredict.
module lab4_branch_resolve_queue #(
    parameter int p_depth     = 4,
    parameter int p_cnt_width = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pred_val,
    output logic                   pred_rdy,
    input  logic [31:0]            pred_pc,
    input  logic                   pred_taken,
    input  logic                   resolve_val,
    output logic                   resolve_rdy,
    input  logic                   resolve_taken,
    output logic                   update_en,
    output logic                   update_val,
    output logic [31:0]            update_pc,
    output logic                   mispred,
    output logic [p_cnt_width-1:0] num_branches,
    output logic [p_cnt_width-1:0] num_mispred
);

    localparam int idx_w = $clog2(p_depth);
    localparam int ptr_w = idx_w + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } entry_t;

    entry_t             mem [p_depth];
    entry_t             head;
    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic [ptr_w-1:0]   count;
    logic               enq;
    logic               deq;
    logic               mis;

    assign pred_rdy    = (count != ptr_w'(p_depth));
    assign resolve_rdy = (count != '0);

    assign head = mem[rd_ptr[idx_w-1:0]];
    assign enq  = pred_val && pred_rdy;
    assign deq  = resolve_val && resolve_rdy;
    assign mis  = deq && (head.taken != resolve_taken);

    // NOTE: storage is not reset; occupancy alone decides which entries are valid.
    // A fetch arriving alongside a mispredict is wrong-path and is never written.
    always_ff @(posedge clk) begin
        if (enq && !mis)
            mem[wr_ptr[idx_w-1:0]] <= '{pc: pred_pc, taken: pred_taken};
    end

    // NOTE: all state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            update_en    <= 1'b0;
            update_val   <= 1'b0;
            update_pc    <= '0;
            mispred      <= 1'b0;
            num_branches <= '0;
            num_mispred  <= '0;
        end else begin
            update_en <= deq;
            mispred   <= mis;

            if (deq) begin
                update_val <= resolve_taken;
                update_pc  <= head.pc;
                if (num_branches != {p_cnt_width{1'b1}})
                    num_branches <= num_branches + p_cnt_width'(1);
                if (mis && num_mispred != {p_cnt_width{1'b1}})
                    num_mispred <= num_mispred + p_cnt_width'(1);
            end

            if (mis) begin
                // Squash: pop the head and drop every younger record.
                rd_ptr <= rd_ptr + ptr_w'(1);
                wr_ptr <= rd_ptr + ptr_w'(1);
                count  <= '0;
            end else begin
                if (enq)
                    wr_ptr <= wr_ptr + ptr_w'(1);
                if (deq)
                    rd_ptr <= rd_ptr + ptr_w'(1);
                case ({enq, deq})
                    2'b10:   count <= count + ptr_w'(1);
                    2'b01:   count <= count - ptr_w'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
